// File: rtl/larpix_trigger_sequencer.sv
// larpix_trigger_sequencer
// Generates external_trigger pulse trains for one or more LArPix chips.
// A sequence is launched from IDLE by start. It produces pulses of
// programmable width and period, in single, burst or continuous mode. Abort
// returns the sequencer to IDLE at the next edge without signalling done.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset
//   start            launch request, sampled only in IDLE
//   abort            stop at the next edge; takes priority over start
//   mode             0 single, 1 burst, 2 continuous, 3 single
//   period           rise-to-rise spacing in clk cycles
//   pulse_width      high time in clk cycles (0 treated as 1)
//   num_triggers     pulses per burst (0 treated as 1)
//   lane_enable      lanes that pulse
//   external_trigger registered trigger outputs, one per lane
//   busy             sequence in progress
//   done             one-cycle pulse on normal completion
//   trig_count       pulses completed in the current or last sequence
module larpix_trigger_sequencer #(
  parameter int NUM_TRIG_OUTS = 4,
  parameter int PERIOD_BITS   = 24,
  parameter int WIDTH_BITS    = 8,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [PERIOD_BITS-1:0]   period,
  input  logic [WIDTH_BITS-1:0]    pulse_width,
  input  logic [COUNT_BITS-1:0]    num_triggers,
  input  logic [NUM_TRIG_OUTS-1:0] lane_enable,
  output logic [NUM_TRIG_OUTS-1:0] external_trigger,
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_BITS-1:0]    trig_count
);

  localparam logic [1:0] MODE_BURST = 2'd1;
  localparam logic [1:0] MODE_CONT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t                   state_r;
  logic [1:0]               mode_r;
  logic [PERIOD_BITS-1:0]   width_r;
  logic [PERIOD_BITS-1:0]   low_r;
  logic [COUNT_BITS-1:0]    num_r;
  logic [NUM_TRIG_OUTS-1:0] lanes_r;
  logic [PERIOD_BITS-1:0]   cnt_r;

  logic [WIDTH_BITS-1:0]    width_norm_s;
  logic [PERIOD_BITS-1:0]   width_ext_s;
  logic [PERIOD_BITS-1:0]   low_norm_s;
  logic [COUNT_BITS-1:0]    num_norm_s;
  logic [COUNT_BITS-1:0]    count_next_s;
  logic                     last_pulse_s;
  logic                     cnt_last_s;

  // Normalise the launch parameters so that zero widths/counts never stall the sequencer.
  always_comb begin
    width_norm_s = pulse_width;
    if (pulse_width == {WIDTH_BITS{1'b0}}) begin
      width_norm_s = WIDTH_BITS'(1);
    end else begin
      width_norm_s = pulse_width;
    end
    width_ext_s = PERIOD_BITS'(width_norm_s);
    // The subtraction is only taken when period > W, so it cannot underflow.
    low_norm_s = PERIOD_BITS'(1);
    if (period > width_ext_s) begin
      low_norm_s = period - width_ext_s;
    end else begin
      low_norm_s = PERIOD_BITS'(1);
    end
    num_norm_s = num_triggers;
    if (num_triggers == {COUNT_BITS{1'b0}}) begin
      num_norm_s = COUNT_BITS'(1);
    end else begin
      num_norm_s = num_triggers;
    end
  end

  // Decide whether the pulse now ending is the last one of the sequence.
  always_comb begin
    count_next_s = trig_count + COUNT_BITS'(1);
    cnt_last_s   = (cnt_r == PERIOD_BITS'(1));
    last_pulse_s = 1'b1;
    case (mode_r)
      MODE_CONT:  last_pulse_s = 1'b0;
      MODE_BURST: last_pulse_s = (count_next_s == num_r);
      default:    last_pulse_s = 1'b1;
    endcase
  end

  // Sequencer FSM with registered trigger, busy, done and count outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      mode_r           <= 2'd0;
      width_r          <= {PERIOD_BITS{1'b0}};
      low_r            <= {PERIOD_BITS{1'b0}};
      num_r            <= {COUNT_BITS{1'b0}};
      lanes_r          <= {NUM_TRIG_OUTS{1'b0}};
      cnt_r            <= {PERIOD_BITS{1'b0}};
      external_trigger <= {NUM_TRIG_OUTS{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
      trig_count       <= {COUNT_BITS{1'b0}};
    end else if (abort) begin
      // Abort truncates any pulse in flight and keeps the count for inspection.
      state_r          <= IDLE;
      external_trigger <= {NUM_TRIG_OUTS{1'b0}};
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r           <= mode;
            width_r          <= width_ext_s;
            low_r            <= low_norm_s;
            num_r            <= num_norm_s;
            lanes_r          <= lane_enable;
            cnt_r            <= width_ext_s;
            trig_count       <= {COUNT_BITS{1'b0}};
            external_trigger <= lane_enable;
            busy             <= 1'b1;
            state_r          <= HIGH;
          end else begin
            external_trigger <= {NUM_TRIG_OUTS{1'b0}};
            busy             <= 1'b0;
          end
        end
        HIGH: begin
          if (cnt_last_s) begin
            trig_count       <= count_next_s;
            external_trigger <= {NUM_TRIG_OUTS{1'b0}};
            if (last_pulse_s) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= IDLE;
            end else begin
              cnt_r   <= low_r;
              state_r <= LOW;
            end
          end else begin
            cnt_r <= cnt_r - PERIOD_BITS'(1);
          end
        end
        LOW: begin
          if (cnt_last_s) begin
            cnt_r            <= width_r;
            external_trigger <= lanes_r;
            state_r          <= HIGH;
          end else begin
            cnt_r <= cnt_r - PERIOD_BITS'(1);
          end
        end
        default: begin
          state_r          <= IDLE;
          external_trigger <= {NUM_TRIG_OUTS{1'b0}};
          busy             <= 1'b0;
          done             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_larpix_trigger_sequencer.sv
// Directed self-checking bench for larpix_trigger_sequencer. A second
// instance with a 4-bit count exercises continuous-mode wrap-around.
module tb_larpix_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        c_start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] period = 24'd0;
  logic [7:0]  pulse_width = 8'd0;
  logic [15:0] num_triggers = 16'd0;
  logic [3:0]  num_c = 4'd0;
  logic [3:0]  lane_enable = 4'd0;

  logic [3:0]  trig;
  logic        busy, done;
  logic [15:0] count;
  logic [3:0]  c_trig;
  logic        c_busy, c_done;
  logic [3:0]  c_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // observation results
  int rises[$];
  int done_cnt, high_cycles, end_i, skew_err;
  logic done_busy, fin;

  larpix_trigger_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .period(period), .pulse_width(pulse_width), .num_triggers(num_triggers),
    .lane_enable(lane_enable), .external_trigger(trig), .busy(busy),
    .done(done), .trig_count(count)
  );

  larpix_trigger_sequencer #(.COUNT_BITS(4)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .abort(abort), .mode(mode),
    .period(period), .pulse_width(pulse_width), .num_triggers(num_c),
    .lane_enable(lane_enable), .external_trigger(c_trig), .busy(c_busy),
    .done(c_done), .trig_count(c_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs a sequence whose start is already asserted; records rise sample
  // indices (0 = sample after the launching edge) until busy drops.
  task automatic observe(input int budget, input int inject_at);
    logic prev;
    prev = 1'b0;
    rises.delete();
    done_cnt = 0; high_cycles = 0; end_i = -1; skew_err = 0;
    done_busy = 1'b1; fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      if (i == inject_at) begin
        start = 1'b1;
        period = 24'd7;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      if (trig != 4'd0 && trig != lane_enable) skew_err++;
      if (trig[0] && !prev) rises.push_back(i);
      if (trig[0]) high_cycles++;
      prev = trig[0];
      if (done) begin
        done_cnt++;
        done_busy = busy;
      end
      if (!busy) begin
        fin = 1'b1;
        end_i = i;
      end
    end
    check("seq_terminates", fin, 1);
  endtask

  initial begin
    int wrapped, wrap_rises, c_done_seen;
    logic c_prev_trig;
    logic [3:0] c_prev;

    // reset state
    tick(); tick();
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    reset = 1'b0;
    tick();

    // single pulse, lanes 0 and 2
    mode = 2'd0; pulse_width = 8'd10; period = 24'd50; num_triggers = 16'd3;
    lane_enable = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("single_high", trig, 4'b0101);
      check("single_busy", busy, 1);
      tick();
    end
    check("single_fall", trig, 0);
    check("single_done", done, 1);
    check("single_busy_low", busy, 0);
    check("single_count", count, 1);
    // restart accepted in the done cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_high", trig, 4'b0101);
    check("restart_done_clear", done, 0);
    check("restart_count_clr", count, 0);
    for (int i = 0; i < 10; i++) tick();
    check("restart_done", done, 1);
    tick();
    check("done_one_cycle", done, 0);

    // burst of 20, period 100, with an ignored start and period change mid-burst
    mode = 2'd1; pulse_width = 8'd20; period = 24'd100; num_triggers = 16'd20;
    lane_enable = 4'b1111;
    start = 1'b1;
    observe(2500, 250);
    check("burst_rises", rises.size(), 20);
    for (int k = 0; k < rises.size(); k++) check("burst_rise_time", rises[k], 100 * k);
    check("burst_high_total", high_cycles, 400);
    check("burst_done_cnt", done_cnt, 1);
    check("burst_done_busy", done_busy, 0);
    check("burst_end", end_i, 1920);
    check("burst_count", count, 20);
    check("burst_skew", skew_err, 0);
    tick();
    check("burst_idle_busy", busy, 0);
    check("burst_idle_done", done, 0);

    // degenerate: all zero in burst mode
    mode = 2'd1; pulse_width = 8'd0; period = 24'd0; num_triggers = 16'd0;
    lane_enable = 4'b0001;
    start = 1'b1;
    observe(50, -5);
    check("degen_rises", rises.size(), 1);
    check("degen_high", high_cycles, 1);
    check("degen_done", done_cnt, 1);
    check("degen_end", end_i, 1);
    check("degen_count", count, 1);

    // period shorter than width: effective period W+1
    mode = 2'd1; pulse_width = 8'd8; period = 24'd5; num_triggers = 16'd3;
    lane_enable = 4'b0011;
    start = 1'b1;
    observe(200, -5);
    check("short_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      check("short_gap1", rises[1] - rises[0], 9);
      check("short_gap2", rises[2] - rises[1], 9);
    end
    check("short_end", end_i, 26);
    check("short_count", count, 3);

    // continuous wrap on the 4-bit-count instance
    mode = 2'd2; pulse_width = 8'd1; period = 24'd2; lane_enable = 4'b1000;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("cont_first_high", c_trig, 4'b1000);
    check("cont_count0", c_count, 0);
    wrapped = 0; wrap_rises = 0; c_done_seen = 0;
    c_prev = c_count; c_prev_trig = c_trig[3];
    for (int i = 1; i < 60; i++) begin
      tick();
      if (c_done) c_done_seen++;
      if (c_prev == 4'd15 && c_count == 4'd0) wrapped++;
      if (wrapped > 0 && c_trig[3] && !c_prev_trig) wrap_rises++;
      c_prev = c_count;
      c_prev_trig = c_trig[3];
    end
    check("cont_wrapped", wrapped, 1);
    check("cont_rises_after_wrap", wrap_rises > 5, 1);
    check("cont_no_done", c_done_seen, 0);
    check("cont_busy", c_busy, 1);
    check("cont_count", c_count, 14);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cont_abort_busy", c_busy, 0);
    check("cont_abort_trig", c_trig, 0);

    // abort in 3rd cycle of second pulse
    mode = 2'd1; pulse_width = 8'd10; period = 24'd15; num_triggers = 16'd5;
    lane_enable = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("abort_pre_trig", trig, 4'b1111);
    check("abort_pre_count", count, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_trig", trig, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", count, 1);
    tick();
    check("abort_done_later", done, 0);

    // start with abort in IDLE: nothing starts, count not cleared
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", busy, 0);
    check("startabort_trig", trig, 0);
    check("startabort_count", count, 1);
    tick();
    check("startabort_busy2", busy, 0);

    // asynchronous reset mid-LOW
    mode = 2'd1; pulse_width = 8'd4; period = 24'd10; num_triggers = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("low_trig", trig, 0);
    check("low_busy", busy, 1);
    check("low_count", count, 1);
    #2 reset = 1'b1;
    #1;
    check("areset_trig", trig, 0);
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    check("areset_count", count, 0);
    reset = 1'b0;
    tick();
    tick();
    check("areset_idle_busy", busy, 0);
    check("areset_idle_trig", trig, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
